mem_ctrl: RTL and testbench

//  Arbitrates the CPU's single byte-wide memory bus (mem_a/mem_dout/mem_wr/mem_din) between

---
 rtl/riscv_defs.sv | 35 +++
 rtl/mem_rr_arb2.sv | 29 ++
 rtl/mem_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared definitions for the memory-side blocks of the core.
// Size codes, controller states and the IO address decode.
package riscv_defs;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Byte lanes touched by an access; the reserved code acts as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    lane_mask = 4'b0001;
      SZ_H:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [1:0] first_set(input logic [3:0] v);
    if (v[0])      first_set = 2'd0;
    else if (v[1]) first_set = 2'd1;
    else if (v[2]) first_set = 2'd2;
    else if (v[3]) first_set = 2'd3;
    else           first_set = 2'd0;
  endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter.
// Port 0 wins ties out of reset; afterwards the loser of the last grant wins.
module mem_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic pref1_q, pref1_d;

  // Grant and next preference; preference moves only on an accepted grant.
  always_comb begin
    gnt0_o  = req0_i & (~req1_i | ~pref1_q);
    gnt1_o  = req1_i & ~gnt0_o;
    pref1_d = pref1_q;
    if (en_i && (gnt0_o || gnt1_o)) pref1_d = gnt0_o;
  end

  // Last-grant register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pref1_q <= 1'b0;
    else         pref1_q <= pref1_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide memory bus controller shared by instruction fetch and LSU.
// Splits accesses into byte beats and assembles little-endian read data.
module mem_ctrl
  import riscv_defs::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        ls_req_in,
  input  logic        ls_wr_in,
  input  logic [1:0]  ls_size_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_wdata_in,
  output logic        ls_done_out,
  output logic [31:0] ls_rdata_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  function automatic logic is_io(input logic [31:0] a);
    return a[RAM_ADDR_WIDTH -: 2] == IO_SEL;
  endfunction

  state_e      state_q, state_d;
  logic        src_ls_q, src_ls_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  got_q, got_d;
  logic        act_q, act_d;
  logic [1:0]  sidx_q, sidx_d;
  logic        pend_q, pend_d;
  logic [1:0]  pidx_q, pidx_d;
  logic        rdy_q, rdy_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_data_q, ls_data_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic        gnt_if, gnt_ls, arb_en;
  logic [31:0] req_addr;

  logic        cap_ok;
  logic [3:0]  got_n, infl, cand;
  logic [31:0] buf_n;

  logic [31:0] wb_base, wb_data, wb_addr;
  logic [1:0]  wb_idx;
  logic [7:0]  wb_byte;
  logic        wb_hold;
  logic [3:0]  wgot;

  assign arb_en = rdy_in & (state_q == ST_IDLE)
                & ~if_done_q & ~ls_done_q;

  mem_rr_arb2 u_arb (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .en_i   (arb_en),
    .req0_i (if_req_in & ~flush_in),
    .req1_i (ls_req_in),
    .gnt0_o (gnt_if),
    .gnt1_o (gnt_ls)
  );

  assign req_addr = gnt_ls ? ls_addr_in : if_addr_in;

  // Read bookkeeping: a beat lands only if the bus was ours on both
  // its issue and capture cycles; lost beats become candidates again.
  always_comb begin
    cap_ok = pend_q & rdy_q;
    got_n  = got_q | (cap_ok ? (4'b0001 << pidx_q) : 4'b0000);
    buf_n  = buf_q;
    if (cap_ok) buf_n[{pidx_q, 3'b000} +: 8] = mem_din;
    infl   = act_q ? (4'b0001 << sidx_q) : 4'b0000;
    cand   = mask_q & ~got_n & ~infl;
  end

  // Next write beat: first beat at grant, else advance past a driven one.
  always_comb begin
    wb_base = addr_q;
    wb_data = wdata_q;
    wb_idx  = sidx_q + {1'b0, mem_wr_q};
    if (state_q == ST_IDLE) begin
      wb_base = ls_addr_in;
      wb_data = ls_wdata_in;
      wb_idx  = 2'd0;
    end
    wb_addr = wb_base + {30'd0, wb_idx};
    wb_byte = wb_data[{wb_idx, 3'b000} +: 8];
    wb_hold = is_io(wb_addr) & io_buffer_full;
    wgot    = got_q | (mem_wr_q ? (4'b0001 << sidx_q) : 4'b0000);
  end

  // Next-state and registered outputs; everything freezes while rdy is low.
  always_comb begin
    state_d    = state_q;
    src_ls_d   = src_ls_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    mask_d     = mask_q;
    got_d      = got_q;
    act_d      = act_q;
    sidx_d     = sidx_q;
    pend_d     = pend_q;
    pidx_d     = pidx_q;
    rdy_d      = rdy_in;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    if_data_d  = if_data_q;
    ls_data_d  = ls_data_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if (rdy_in) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_en && (gnt_if || gnt_ls)) begin
            src_ls_d = gnt_ls;
            addr_d   = req_addr;
            wdata_d  = ls_wdata_in;
            mask_d   = gnt_ls ? lane_mask(ls_size_in) : 4'hf;
            got_d    = 4'h0;
            buf_d    = 32'h0;
            pend_d   = 1'b0;
            sidx_d   = 2'd0;
            if (gnt_ls && ls_wr_in) begin
              state_d    = ST_WRITE;
              mem_wr_d   = ~wb_hold;
              mem_a_d    = wb_hold ? 32'h0 : wb_addr;
              mem_dout_d = wb_hold ? 8'h0 : wb_byte;
            end else begin
              state_d = ST_READ;
              act_d   = 1'b1;
              mem_a_d = req_addr;
            end
          end
        end
        ST_READ: begin
          got_d   = got_n;
          buf_d   = buf_n;
          pend_d  = act_q;
          pidx_d  = sidx_q;
          act_d   = 1'b0;
          mem_a_d = 32'h0;
          if (!src_ls_q && flush_in) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
          end else if (got_n == mask_q) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            if (src_ls_q) begin
              ls_done_d = 1'b1;
              ls_data_d = buf_n;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_n;
            end
          end else if (cand != 4'h0) begin
            act_d   = 1'b1;
            sidx_d  = first_set(cand);
            mem_a_d = addr_q + {30'd0, first_set(cand)};
          end
        end
        ST_WRITE: begin
          got_d      = wgot;
          sidx_d     = wb_idx;
          mem_wr_d   = 1'b0;
          mem_a_d    = 32'h0;
          mem_dout_d = 8'h0;
          if (wgot == mask_q) begin
            state_d   = ST_IDLE;
            ls_done_d = 1'b1;
          end else if (!wb_hold) begin
            mem_wr_d   = 1'b1;
            mem_a_d    = wb_addr;
            mem_dout_d = wb_byte;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      src_ls_q   <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      mask_q     <= 4'h0;
      got_q      <= 4'h0;
      act_q      <= 1'b0;
      sidx_q     <= 2'd0;
      pend_q     <= 1'b0;
      pidx_q     <= 2'd0;
      rdy_q      <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'h0;
      ls_data_q  <= 32'h0;
      mem_a_q    <= 32'h0;
      mem_dout_q <= 8'h0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ls_q   <= src_ls_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      mask_q     <= mask_d;
      got_q      <= got_d;
      act_q      <= act_d;
      sidx_q     <= sidx_d;
      pend_q     <= pend_d;
      pidx_q     <= pidx_d;
      rdy_q      <= rdy_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_data_q  <= ls_data_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign if_done_out  = if_done_q;
  assign if_data_out  = if_data_q;
  assign ls_done_out  = ls_done_q;
  assign ls_rdata_out = ls_data_q;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model.
// Expected done data and bus writes are queued at stimulus time.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        ls_req_in;
  logic        ls_wr_in;
  logic [1:0]  ls_size_in;
  logic [31:0] ls_addr_in;
  logic [31:0] ls_wdata_in;
  logic        ls_done_out;
  logic [31:0] ls_rdata_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .if_req_in      (if_req_in),
    .if_addr_in     (if_addr_in),
    .if_done_out    (if_done_out),
    .if_data_out    (if_data_out),
    .ls_req_in      (ls_req_in),
    .ls_wr_in       (ls_wr_in),
    .ls_size_in     (ls_size_in),
    .ls_addr_in     (ls_addr_in),
    .ls_wdata_in    (ls_wdata_in),
    .ls_done_out    (ls_done_out),
    .ls_rdata_out   (ls_rdata_out),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } ld_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] ifq[$];
  ld_t         lsq[$];
  wr_t         wq[$];
  logic [7:0]  ram [0:65535];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM: read data one cycle after the address; garbage if bus was lent.
  always @(posedge clk_in) begin
    mem_din <= rdy_in ? ram[mem_a[15:0]] : 8'hA5;
    if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] <= mem_dout;
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13;
    ram[16'h1001] = 8'h05;
    ram[16'h1002] = 8'h00;
    ram[16'h1003] = 8'h00;
  end

  // Scoreboard: pop expectations as the DUT completes or writes.
  always @(negedge clk_in) begin
    ld_t l;
    wr_t w;
    if (rst_n_in) begin
      if (if_done_out) begin
        if (ifq.size() == 0) chk("if_done_unexp", {31'b0, if_done_out}, 32'd0);
        else chk("if_data", if_data_out, ifq.pop_front());
      end
      if (ls_done_out) begin
        if (lsq.size() == 0) chk("ls_done_unexp", {31'b0, ls_done_out}, 32'd0);
        else begin
          l = lsq.pop_front();
          if (l.chk) chk("ls_data", ls_rdata_out, l.data);
        end
      end
      if (mem_wr) begin
        if (wq.size() == 0) chk("wr_unexp", {31'b0, mem_wr}, 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", mem_a, w.a);
          chk("wr_data", {24'b0, mem_dout}, {24'b0, w.d});
        end
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk_in);
    #1;
  endtask

  // Wait for the next done pulse; requester drops req on that edge.
  task automatic wait_any(output logic is_ls, output int lat);
    is_ls = 1'b0;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (if_done_out || ls_done_out) begin
        is_ls = ls_done_out;
        lat = cyc - t0;
        cyc_start();
        if (is_ls) ls_req_in = 1'b0;
        else if_req_in = 1'b0;
        return;
      end
    end
  endtask

  task automatic ls_drive(input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    ls_req_in = 1'b1;
    ls_wr_in = wr;
    ls_size_in = sz;
    ls_addr_in = a;
    ls_wdata_in = d;
  endtask

  initial begin
    logic w;
    int   l;
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    if_req_in = 1'b0;
    if_addr_in = 32'h0;
    ls_req_in = 1'b0;
    ls_wr_in = 1'b0;
    ls_size_in = 2'b00;
    ls_addr_in = 32'h0;
    ls_wdata_in = 32'h0;
    io_buffer_full = 1'b0;

    #12;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst_if_done", {31'b0, if_done_out}, 32'h0);
    chk("rst_ls_done", {31'b0, ls_done_out}, 32'h0);
    chk("rst_if_data", if_data_out, 32'h0);
    chk("rst_ls_data", ls_rdata_out, 32'h0);
    cyc_start();
    rst_n_in = 1'b1;
    cyc_start();

    // Round robin: IF first after reset, then LS, then IF again.
    if_req_in = 1'b1;
    if_addr_in = 32'h1000;
    ls_drive(1'b0, 2'b11, 32'h1000, 32'h0);
    t0 = cyc;
    ifq.push_back(32'h0000_0513);
    lsq.push_back('{1'b1, 32'h0000_0513});
    wait_any(w, l);
    chk("rr1_src", {31'b0, w}, 32'd0);
    chk("rr1_lat", l, 32'd6);
    wait_any(w, l);
    chk("rr2_src", {31'b0, w}, 32'd1);
    chk("rr2_lat", l, 32'd13);
    if_req_in = 1'b1;
    ls_drive(1'b0, 2'b10, 32'h1000, 32'h0);
    t0 = cyc;
    ifq.push_back(32'h0000_0513);
    lsq.push_back('{1'b1, 32'h0000_0513});
    wait_any(w, l);
    chk("rr3_src", {31'b0, w}, 32'd0);
    chk("rr3_lat", l, 32'd6);
    wait_any(w, l);
    chk("rr4_src", {31'b0, w}, 32'd1);

    // Word fetch: address sequence and done timing.
    if_req_in = 1'b1;
    if_addr_in = 32'h1000;
    t0 = cyc;
    ifq.push_back(32'h0000_0513);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) cyc_start();
      @(negedge clk_in);
      chk($sformatf("if_a_c%0d", c), mem_a,
          (c >= 1 && c <= 4) ? 32'h1000 + c - 1 : 32'h0);
      chk($sformatf("if_done_c%0d", c), {31'b0, if_done_out},
          {31'b0, c == 6});
    end
    cyc_start();
    if_req_in = 1'b0;

    // Half store then half load of the same bytes.
    ls_drive(1'b1, 2'b01, 32'h2001, 32'h1234_BEEF);
    t0 = cyc;
    wq.push_back('{32'h2001, 8'hEF});
    wq.push_back('{32'h2002, 8'hBE});
    lsq.push_back('{1'b0, 32'h0});
    wait_any(w, l);
    chk("sth_src", {31'b0, w}, 32'd1);
    chk("sth_lat", l, 32'd3);
    ls_drive(1'b0, 2'b01, 32'h2001, 32'h0);
    t0 = cyc;
    lsq.push_back('{1'b1, 32'h0000_BEEF});
    wait_any(w, l);
    chk("ldh_lat", l, 32'd4);

    // IO byte store held off by a full output buffer.
    ls_drive(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
    io_buffer_full = 1'b1;
    t0 = cyc;
    wq.push_back('{32'h0003_0000, 8'h41});
    lsq.push_back('{1'b0, 32'h0});
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) cyc_start();
      io_buffer_full = (c < 5);
      @(negedge clk_in);
      chk($sformatf("io_wr_c%0d", c), {31'b0, mem_wr}, {31'b0, c == 6});
      chk($sformatf("io_done_c%0d", c), {31'b0, ls_done_out},
          {31'b0, c == 7});
    end
    cyc_start();
    ls_req_in = 1'b0;

    // Word load with the bus lent away for three cycles.
    ls_drive(1'b0, 2'b10, 32'h1000, 32'h0);
    t0 = cyc;
    lsq.push_back('{1'b1, 32'h0000_0513});
    l = -1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) cyc_start();
      rdy_in = !(c >= 3 && c <= 5);
      @(negedge clk_in);
      if (ls_done_out) begin
        l = c;
        break;
      end
    end
    cyc_start();
    ls_req_in = 1'b0;
    rdy_in = 1'b1;
    chk("rdy_lat_9_or_10", {31'b0, (l == 9 || l == 10)}, 32'd1);

    // Flush aborts the fetch; the waiting LS load goes next.
    if_req_in = 1'b1;
    if_addr_in = 32'h1000;
    ls_drive(1'b0, 2'b00, 32'h2002, 32'h0);
    t0 = cyc;
    lsq.push_back('{1'b1, 32'h0000_00BE});
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) cyc_start();
      if (c == 2) flush_in = 1'b1;
      if (c == 3) begin
        flush_in = 1'b0;
        if_req_in = 1'b0;
      end
      if (c == 7) ls_req_in = 1'b0;
      @(negedge clk_in);
      chk($sformatf("fl_no_ifdone_c%0d", c), {31'b0, if_done_out}, 32'd0);
      if (c == 3) chk("fl_a_idle", mem_a, 32'h0);
      if (c == 4) chk("fl_ls_a", mem_a, 32'h2002);
      if (c == 6) chk("fl_ls_done", {31'b0, ls_done_out}, 32'd1);
    end
    cyc_start();

    // Asynchronous reset in the middle of a word store.
    ls_drive(1'b1, 2'b10, 32'h2100, 32'hA1B2_C3D4);
    t0 = cyc;
    wq.push_back('{32'h2100, 8'hD4});
    @(negedge clk_in);
    cyc_start();
    @(negedge clk_in);
    chk("rw_wr_c1", {31'b0, mem_wr}, 32'd1);
    cyc_start();
    chk("rw_wr_c2", {31'b0, mem_wr}, 32'd1);
    #1;
    rst_n_in = 1'b0;
    ls_req_in = 1'b0;
    #1;
    chk("rw_async_wr", {31'b0, mem_wr}, 32'd0);
    chk("rw_async_a", mem_a, 32'h0);
    cyc_start();
    cyc_start();
    rst_n_in = 1'b1;
    cyc_start();
    @(negedge clk_in);
    chk("post_rst_a", mem_a, 32'h0);
    chk("post_rst_done", {31'b0, ls_done_out}, 32'd0);

    chk("ifq_left", ifq.size(), 32'd0);
    chk("lsq_left", lsq.size(), 32'd0);
    chk("wq_left", wq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
